alu_control_unit: RTL and testbench

Combined sequencing FSM and 16-bit registered ALU for the 8-register, 16-bit teaching processor core. It accepts one instruction per `run` transaction and walks it through fixed states. In those states it strobes the operand-latch (`en_s`), result-capture (`en_c`) and register-file write-enable (`en_reg`) controls. It also computes the ALU result on the core's latched operands. The enclosing core owns the register file, operand registers and memory.

---
 rtl/alu_control_unit.sv | 157 +++++++++++++++
 tb/tb_alu_control_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_control_unit.sv
// alu_control_unit
// Sequencing FSM plus 16-bit registered ALU for the 8-register teaching core.
// One instruction per run transaction walks IDLE -> LOAD -> EXEC -> CAPT ->
// WRITE -> DONE -> IDLE, strobing en_s (LOAD), en_c (CAPT), en_reg (WRITE)
// and done (DONE). Every transition, the ir load and the ALU update only
// happen on edges that sample run = 1; otherwise everything holds.
//
// Optional build macro: ALU_SELFCHECK_EN
//   When defined, a simulation-only checker recomputes each ALU result from
//   the previous cycle's operands and sel and prints "ALU mismatch" with the
//   operands, sel and both results on any disagreement. It never touches the
//   outputs. When undefined, the checker is absent and nothing is printed.

module alu_control_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [15:0] instruction,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic        en_s,
  output logic        en_c,
  output logic [7:0]  en_reg,
  output logic        done,
  output logic [15:0] alu_out
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    EXEC  = 3'd2,
    CAPT  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [15:0] ir;

  // Instruction fields, always taken from the held copy in ir
  logic [2:0]  ir_rx;
  logic [2:0]  ir_sel;
  logic [1:0]  ir_fmt;
  logic        ir_writes_reg;

  // Ry and imm8 travel to the core through in_b, so this block never reads them
  logic        unused_ir_bits;

  assign ir_rx          = ir[15:13];
  assign ir_sel         = ir[4:2];
  assign ir_fmt         = ir[1:0];
  assign ir_writes_reg  = (ir_fmt != 2'b11);
  assign unused_ir_bits = ^ir[12:5];

  // Pure ALU function shared by the datapath register and the optional checker
  function automatic logic [15:0] alu_compute(input logic [15:0] a,
                                              input logic [15:0] b,
                                              input logic [2:0]  sel);
    logic [15:0] r;
    r = 16'h0000;
    case (sel)
      3'd0:    r = a + b;
      3'd1:    r = a - b;
      3'd2:    r = a & b;
      3'd3:    r = a | b;
      3'd4:    r = a ^ b;
      3'd5:    r = a << b[3:0];
      3'd6:    r = a >> b[3:0];
      3'd7:    r = ~a;
      default: r = 16'h0000;
    endcase
    return r;
  endfunction

  // One-hot write enable for the destination register
  function automatic logic [7:0] reg_decode(input logic [2:0] idx);
    logic [7:0] onehot;
    onehot = 8'h00;
    onehot[idx] = 1'b1;
    return onehot;
  endfunction

  // The sequence is a fixed ring; there are no branches out of it
  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE:    next_state = LOAD;
      LOAD:    next_state = EXEC;
      EXEC:    next_state = CAPT;
      CAPT:    next_state = WRITE;
      WRITE:   next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State, instruction register and registered strobes advance together on run
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      ir     <= 16'h0000;
      en_s   <= 1'b0;
      en_c   <= 1'b0;
      done   <= 1'b0;
      en_reg <= 8'h00;
    end else if (run) begin
      state <= next_state;
      if (state == IDLE) begin
        ir <= instruction;
      end
      en_s   <= (next_state == LOAD);
      en_c   <= (next_state == CAPT);
      done   <= (next_state == DONE);
      en_reg <= ((next_state == WRITE) && ir_writes_reg) ? reg_decode(ir_rx) : 8'h00;
    end
  end

  // ALU result register updates on every run edge regardless of state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_out <= 16'h0000;
    end else if (run) begin
      alu_out <= alu_compute(in_a, in_b, ir_sel);
    end
  end

`ifdef ALU_SELFCHECK_EN
  logic [15:0] chk_a;
  logic [15:0] chk_b;
  logic [2:0]  chk_sel;
  logic        chk_valid;
  logic [15:0] chk_expect;

  assign chk_expect = alu_compute(chk_a, chk_b, chk_sel);

  // Remember the operands behind each ALU update and compare one edge later
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      chk_a     <= 16'h0000;
      chk_b     <= 16'h0000;
      chk_sel   <= 3'd0;
      chk_valid <= 1'b0;
    end else if (run) begin
      if (chk_valid && (alu_out !== chk_expect)) begin
        $display("ALU mismatch: a=%h b=%h sel=%0d expected=%h got=%h",
                 chk_a, chk_b, chk_sel, chk_expect, alu_out);
      end
      chk_a     <= in_a;
      chk_b     <= in_b;
      chk_sel   <= ir_sel;
      chk_valid <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_control_unit.sv
// tb_alu_control_unit
// Directed steps followed by a randomized run, each cycle compared against a
// behavioural model: an instruction is a position 0..5 in a six-step walk,
// and the ALU is plain integer arithmetic modulo 65536.

module tb_alu_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [15:0] instruction;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        en_s;
  logic        en_c;
  logic [7:0]  en_reg;
  logic        done;
  logic [15:0] alu_out;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  int          m_pos;
  logic [15:0] m_ir;
  logic [15:0] m_alu;

  alu_control_unit dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .instruction (instruction),
    .in_a        (in_a),
    .in_b        (in_b),
    .en_s        (en_s),
    .en_c        (en_c),
    .en_reg      (en_reg),
    .done        (done),
    .alu_out     (alu_out)
  );

  always #5 clk = ~clk;

  // Hard time limit so the bench can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  function automatic logic [15:0] alu_ref(input logic [15:0] a, input logic [15:0] b,
                                          input logic [2:0] sel);
    longint ia;
    longint ib;
    longint sh;
    longint r;
    ia = longint'(a);
    ib = longint'(b);
    sh = longint'(1) << (ib % 16);
    r  = 0;
    case (sel)
      3'd0: r = (ia + ib) % 65536;
      3'd1: r = (ia - ib + 65536) % 65536;
      3'd2: r = longint'(a & b);
      3'd3: r = longint'(a | b);
      3'd4: r = longint'(a ^ b);
      3'd5: r = (ia * sh) % 65536;
      3'd6: r = ia / sh;
      3'd7: r = 65535 - ia;
      default: r = 0;
    endcase
    return 16'(r);
  endfunction

  task automatic check_output(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Compare every output against the model's view of the current step
  task automatic check_model();
    logic [15:0] exp_reg;
    exp_reg = 16'h0000;
    if (m_pos == 4 && m_ir[1:0] != 2'b11) exp_reg = 16'(1) << m_ir[15:13];
    check_output("en_s",    16'(en_s),   16'(m_pos == 1));
    check_output("en_c",    16'(en_c),   16'(m_pos == 3));
    check_output("done",    16'(done),   16'(m_pos == 5));
    check_output("en_reg",  16'(en_reg), exp_reg);
    check_output("alu_out", alu_out,     m_alu);
  endtask

  // Drive one cycle of inputs, advance the model at the edge, then check
  task automatic apply_stimulus(input logic r, input logic [15:0] ins,
                                input logic [15:0] a, input logic [15:0] b);
    run = r; instruction = ins; in_a = a; in_b = b;
    @(posedge clk);
    if (r) begin
      m_alu = alu_ref(a, b, m_ir[4:2]);
      if (m_pos == 0) m_ir = ins;
      m_pos = (m_pos + 1) % 6;
    end
    #1;
    check_model();
  endtask

  task automatic model_reset();
    m_pos = 0;
    m_ir  = 16'h0000;
    m_alu = 16'h0000;
  endtask

  logic [15:0] sweep_exp [8];
  logic [15:0] frozen;
  int          waited;

  initial begin
    sweep_exp = '{16'h8004, 16'h7FFE, 16'h0001, 16'h8003,
                  16'h8002, 16'h0008, 16'h1000, 16'h7FFE};
    model_reset();
    reset = 1'b1; run = 1'b0; instruction = 16'h0000; in_a = 16'h0000; in_b = 16'h0000;
    #12;
    $display("[TB] reset state");
    check_output("reset_en_s", 16'(en_s), 16'h0000);
    check_output("reset_en_reg", 16'(en_reg), 16'h0000);
    check_output("reset_alu", alu_out, 16'h0000);
    reset = 1'b0;

    // Reset asserted mid-LOAD aborts the instruction
    $display("[TB] reset mid-LOAD");
    apply_stimulus(1'b1, 16'h2400, 16'd9, 16'd9);
    check_output("midload_en_s", 16'(en_s), 16'h0001);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_output("abort_en_s", 16'(en_s), 16'h0000);
    check_output("abort_alu", alu_out, 16'h0000);
    #1 reset = 1'b0;
    apply_stimulus(1'b0, 16'h2400, 16'd0, 16'd0);
    check_output("after_reset_idle_en_s", 16'(en_s), 16'h0000);
    apply_stimulus(1'b1, 16'h2400, 16'd0, 16'd0);
    check_output("fresh_load_en_s", 16'(en_s), 16'h0001);
    for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 16'h0000, 16'd0, 16'd0);

    // Register-register add R1 <= 3 + 4
    $display("[TB] add R1");
    apply_stimulus(1'b1, 16'h2400, 16'd3, 16'd4);
    check_output("add_en_s_c1", 16'(en_s), 16'h0001);
    apply_stimulus(1'b1, 16'h2400, 16'd3, 16'd4);
    apply_stimulus(1'b1, 16'h2400, 16'd3, 16'd4);
    check_output("add_en_c_c3", 16'(en_c), 16'h0001);
    check_output("add_alu_c3", alu_out, 16'd7);
    apply_stimulus(1'b1, 16'h2400, 16'd3, 16'd4);
    check_output("add_en_reg_c4", 16'(en_reg), 16'h0002);
    apply_stimulus(1'b1, 16'h2400, 16'd3, 16'd4);
    check_output("add_done_c5", 16'(done), 16'h0001);
    apply_stimulus(1'b1, 16'h2400, 16'd3, 16'd4);

    // Immediate subtract R7 <= 2 - 5
    $display("[TB] immediate sub R7");
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 16'hE0A5, 16'd2, 16'd5);
    check_output("imm_alu_capt", alu_out, 16'hFFFD);
    apply_stimulus(1'b1, 16'hE0A5, 16'd2, 16'd5);
    check_output("imm_en_reg_write", 16'(en_reg), 16'h0080);
    for (int i = 0; i < 2; i++) apply_stimulus(1'b1, 16'hE0A5, 16'd2, 16'd5);

    // Store never writes the register file
    $display("[TB] store");
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(1'b1, 16'h4007, 16'd1, 16'd1);
      check_output("store_en_reg", 16'(en_reg), 16'h0000);
      if (i == 4) check_output("store_done_c5", 16'(done), 16'h0001);
    end

    // Stall three cycles in EXEC
    $display("[TB] stall in EXEC");
    apply_stimulus(1'b1, 16'h0010, 16'h1234, 16'h00FF);
    apply_stimulus(1'b1, 16'h0010, 16'h1234, 16'h00FF);
    frozen = alu_out;
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b0, 16'h0010, 16'($urandom), 16'($urandom));
      check_output("stall_alu_frozen", alu_out, frozen);
      check_output("stall_en_c_low", 16'(en_c), 16'h0000);
    end
    waited = 0;
    while (en_c !== 1'b1 && waited < 10) begin
      apply_stimulus(1'b1, 16'h0010, 16'h1234, 16'h00FF);
      waited++;
    end
    check_output("stall_en_c_delay", 16'(waited), 16'd1);
    while (m_pos != 0 && waited < 20) begin
      apply_stimulus(1'b1, 16'h0000, 16'h0000, 16'h0000);
      waited++;
    end

    // sel sweep with A=0x8001, B=0x0003
    $display("[TB] sel sweep");
    for (int s = 0; s < 8; s++) begin
      for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 16'(s << 2), 16'h8001, 16'h0003);
      check_output($sformatf("sweep_sel%0d", s), alu_out, sweep_exp[s]);
      for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 16'(s << 2), 16'h8001, 16'h0003);
    end

    // Random run gaps, instructions and operands against the model
    $display("[TB] random");
    for (int i = 0; i < 600; i++) begin
      apply_stimulus(($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom), 16'($urandom));
    end
    for (int i = 0; i < 6 && m_pos != 0; i++) begin
      apply_stimulus(1'b1, 16'($urandom), 16'($urandom), 16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
